// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset controller: opcodes,
// funct codes, state encoding, ALU operation enum and datapath select codes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF0 = 3'd0,
        S_IF1 = 3'd1,
        S_ID  = 3'd2,
        S_EX  = 3'd3,
        S_MEM = 3'd4,
        S_WB  = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_LUI = 4'd9
    } alu_op_e;

    typedef enum logic [3:0] {
        C_RTYPE, C_ITYPE, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_ILL
    } iclass_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_RS     = 2'b01;
    localparam logic [1:0] PC_BRANCH = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    localparam logic [1:0] RF_DST_RT = 2'b00;
    localparam logic [1:0] RF_DST_RD = 2'b01;
    localparam logic [1:0] RF_DST_RA = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC4 = 2'b10;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: opcode/funct to instruction class,
// ALU operation, immediate extension mode and an unsupported-instruction flag.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output iclass_e    iclass,
    output alu_op_e    alu_op,
    output logic       imm_zext,
    output logic       illegal
);

    always_comb begin
        iclass   = C_ILL;
        alu_op   = ALU_ADD;
        imm_zext = 1'b0;
        case (op)
            OP_RTYPE: begin
                iclass = C_RTYPE;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLL:  alu_op = ALU_SLL;
                    FN_SRL:  alu_op = ALU_SRL;
                    FN_JR:   iclass = C_JR;
                    default: iclass = C_ILL;
                endcase
            end
            OP_ADDI: iclass = C_ITYPE;
            OP_ANDI: begin iclass = C_ITYPE; alu_op = ALU_AND; imm_zext = 1'b1; end
            OP_ORI:  begin iclass = C_ITYPE; alu_op = ALU_OR;  imm_zext = 1'b1; end
            OP_XORI: begin iclass = C_ITYPE; alu_op = ALU_XOR; imm_zext = 1'b1; end
            OP_LUI:  begin iclass = C_ITYPE; alu_op = ALU_LUI; end
            OP_LW:   iclass = C_LW;
            OP_SW:   iclass = C_SW;
            // Branches compare rs/rt by subtraction; zf reports equality.
            OP_BEQ:  begin iclass = C_BEQ; alu_op = ALU_SUB; end
            OP_BNE:  begin iclass = C_BNE; alu_op = ALU_SUB; end
            OP_J:    iclass = C_J;
            OP_JAL:  iclass = C_JAL;
            default: iclass = C_ILL;
        endcase
    end

    assign illegal = (iclass == C_ILL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: fetch, decode, execute, memory handshake with
// timeout, and write-back. All strobes are decoded from registered state.
//   state | meaning
//   IF0   | ROM read in flight
//   IF1   | instruction word valid, load IR and op/funct
//   ID    | decode; jumps and illegal instructions retire here
//   EX    | ALU operation; branches retire here
//   MEM   | data-memory request held until ack or timeout
//   WB    | register-file write and PC+4
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 255,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_code,
    input  logic        zf,
    input  logic        mem_ack,
    output logic [1:0]  pc_s,
    output logic        pc_we,
    output logic        ir_we,
    output logic        rf_we,
    output logic [1:0]  rf_dst,
    output logic [1:0]  wd_sel,
    output logic [3:0]  alu_op,
    output logic        alu_src_b,
    output logic        imm_zext,
    output logic        mem_req,
    output logic        mem_we,
    output logic        illegal,
    output logic        bus_err,
    output logic [2:0]  state
);

    state_e           state_q, state_d;
    logic [5:0]       op_q, op_d, funct_q, funct_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d, bus_err_q, bus_err_d;

    iclass_e iclass;
    alu_op_e dec_alu_op;
    logic    dec_imm_zext, dec_illegal;
    logic    unused_inst_bits;

    assign unused_inst_bits = ^inst_code[25:6];

    ctrl_decode u_decode (
        .op       (op_q),
        .funct    (funct_q),
        .iclass   (iclass),
        .alu_op   (dec_alu_op),
        .imm_zext (dec_imm_zext),
        .illegal  (dec_illegal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IF0;
            op_q      <= '0;
            funct_q   <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            funct_q   <= funct_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        funct_d   = funct_q;
        cnt_d     = '0;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        pc_s      = PC_PLUS4;
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        rf_we     = 1'b0;
        rf_dst    = RF_DST_RT;
        wd_sel    = WD_ALU;
        alu_op    = ALU_ADD;
        alu_src_b = 1'b0;
        imm_zext  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            S_IF0: state_d = S_IF1;
            S_IF1: begin
                ir_we   = 1'b1;
                op_d    = inst_code[31:26];
                funct_d = inst_code[5:0];
                state_d = S_ID;
            end
            S_ID: begin
                state_d = S_IF0;
                pc_we   = 1'b1;
                if (dec_illegal) begin
                    illegal_d = 1'b1;
                end else begin
                    case (iclass)
                        C_J:  pc_s = PC_JUMP;
                        C_JR: pc_s = PC_RS;
                        C_JAL: begin
                            pc_s   = PC_JUMP;
                            rf_we  = 1'b1;
                            rf_dst = RF_DST_RA;
                            wd_sel = WD_PC4;
                        end
                        default: begin
                            pc_we   = 1'b0;
                            state_d = S_EX;
                        end
                    endcase
                end
            end
            S_EX: begin
                alu_op    = dec_alu_op;
                alu_src_b = (iclass == C_ITYPE) || (iclass == C_LW) || (iclass == C_SW);
                imm_zext  = dec_imm_zext;
                case (iclass)
                    C_BEQ, C_BNE: begin
                        pc_we   = 1'b1;
                        pc_s    = ((iclass == C_BEQ) == zf) ? PC_BRANCH : PC_PLUS4;
                        state_d = S_IF0;
                    end
                    C_LW, C_SW: state_d = S_MEM;
                    default:    state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (iclass == C_SW);
                if (mem_ack) begin
                    if (iclass == C_SW) begin
                        pc_we   = 1'b1;
                        state_d = S_IF0;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
                    // Abort after WAIT_MAX request cycles; the load never writes back.
                    bus_err_d = 1'b1;
                    pc_we     = 1'b1;
                    state_d   = S_IF0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                rf_dst  = (iclass == C_RTYPE) ? RF_DST_RD : RF_DST_RT;
                wd_sel  = (iclass == C_LW) ? WD_MEM : WD_ALU;
                pc_we   = 1'b1;
                state_d = S_IF0;
            end
            default: state_d = S_IF0;
        endcase
    end

    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed cases plus random
// instructions, checked per instruction against a cycle-count/outcome model.
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    localparam int WAIT_MAX = 4;
    localparam int NO_ACK   = 1000;

    typedef enum int {K_R, K_I, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_JR, K_ILL} kind_e;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst_code = '0;
    logic        zf = 1'b0;
    logic        mem_ack = 1'b0;
    logic [1:0]  pc_s, rf_dst, wd_sel;
    logic        pc_we, ir_we, rf_we, alu_src_b, imm_zext, mem_req, mem_we, illegal, bus_err;
    logic [3:0]  alu_op;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;
    bit exp_illegal = 1'b0;
    bit exp_bus_err = 1'b0;

    multicycle_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .inst_code (inst_code),
        .zf        (zf),
        .mem_ack   (mem_ack),
        .pc_s      (pc_s),
        .pc_we     (pc_we),
        .ir_we     (ir_we),
        .rf_we     (rf_we),
        .rf_dst    (rf_dst),
        .wd_sel    (wd_sel),
        .alu_op    (alu_op),
        .alu_src_b (alu_src_b),
        .imm_zext  (imm_zext),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .illegal   (illegal),
        .bus_err   (bus_err),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic kind_e classify(input logic [31:0] inst);
        logic [5:0] op, fn;
        op = inst[31:26];
        fn = inst[5:0];
        case (op)
            6'h00: begin
                if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02})
                    return K_R;
                if (fn == 6'h08) return K_JR;
                return K_ILL;
            end
            6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F: return K_I;
            6'h23: return K_LW;
            6'h2B: return K_SW;
            6'h04: return K_BEQ;
            6'h05: return K_BNE;
            6'h02: return K_J;
            6'h03: return K_JAL;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [3:0] ref_alu(input logic [31:0] inst);
        logic [5:0] op, fn;
        op = inst[31:26];
        fn = inst[5:0];
        case (op)
            6'h00: case (fn)
                6'h22: return ALU_SUB;
                6'h24: return ALU_AND;
                6'h25: return ALU_OR;
                6'h26: return ALU_XOR;
                6'h27: return ALU_NOR;
                6'h2A: return ALU_SLT;
                6'h00: return ALU_SLL;
                6'h02: return ALU_SRL;
                default: return ALU_ADD;
            endcase
            6'h0C: return ALU_AND;
            6'h0D: return ALU_OR;
            6'h0E: return ALU_XOR;
            6'h0F: return ALU_LUI;
            6'h04, 6'h05: return ALU_SUB;
            default: return ALU_ADD;
        endcase
    endfunction

    // Runs one instruction starting at an IF0 negedge; ends at the next one.
    // d = number of MEM cycles before mem_ack is raised.
    task automatic run_instr(input string name, input logic [31:0] inst, input bit z, input int d);
        kind_e k;
        bit timeout, done;
        int cyc, mc, pcc, irc, rfc, exp_cyc, exp_mc;
        logic [1:0] pcs, dst, wds, exp_pcs;
        logic mwe, ex_seen, ex_srcb, ex_zext;
        logic [3:0] ex_alu;
        k = classify(inst);
        timeout = (k == K_LW || k == K_SW) && (d >= WAIT_MAX);
        cyc = 0; mc = 0; pcc = 0; irc = 0; rfc = 0; done = 1'b0;
        pcs = '0; dst = '0; wds = '0; mwe = 1'b0; ex_seen = 1'b0;
        ex_alu = '0; ex_srcb = 1'b0; ex_zext = 1'b0;
        check({name, " start_state"}, state, 0);
        inst_code = inst;
        zf = z;
        for (int i = 0; i < 40 && !done; i++) begin
            if (mem_req) begin
                mem_ack = (mc >= d);
                mc++;
            end else begin
                mem_ack = 1'($urandom_range(0, 1));
            end
            #1;
            cyc++;
            if (ir_we) irc++;
            if (state == 3'd3) begin
                ex_seen = 1'b1; ex_alu = alu_op; ex_srcb = alu_src_b; ex_zext = imm_zext;
            end
            if (rf_we) begin rfc++; dst = rf_dst; wds = wd_sel; end
            if (mem_req) mwe = mem_we;
            if (pc_we) begin pcc++; pcs = pc_s; done = 1'b1; end
            @(negedge clk);
        end
        case (k)
            K_J, K_JAL, K_JR, K_ILL: exp_cyc = 3;
            K_BEQ, K_BNE:            exp_cyc = 4;
            K_R, K_I:                exp_cyc = 5;
            K_SW:                    exp_cyc = timeout ? 4 + WAIT_MAX : 5 + d;
            default:                 exp_cyc = timeout ? 4 + WAIT_MAX : 6 + d;
        endcase
        case (k)
            K_J, K_JAL: exp_pcs = 2'b11;
            K_JR:       exp_pcs = 2'b01;
            K_BEQ:      exp_pcs = z ? 2'b10 : 2'b00;
            K_BNE:      exp_pcs = z ? 2'b00 : 2'b10;
            default:    exp_pcs = 2'b00;
        endcase
        exp_mc = (k == K_LW || k == K_SW) ? (timeout ? WAIT_MAX : d + 1) : 0;
        check({name, " cycles"}, cyc, exp_cyc);
        check({name, " pc_we_pulses"}, pcc, 1);
        check({name, " pc_s"}, pcs, exp_pcs);
        check({name, " ir_we_pulses"}, irc, 1);
        check({name, " mem_req_cycles"}, mc, exp_mc);
        if (exp_mc > 0) check({name, " mem_we"}, mwe, k == K_SW);
        if (k == K_JAL || k == K_R || k == K_I || (k == K_LW && !timeout)) begin
            check({name, " rf_we_cycles"}, rfc, 1);
            check({name, " rf_dst"}, dst, (k == K_JAL) ? 2'b10 : (k == K_R) ? 2'b01 : 2'b00);
            check({name, " wd_sel"}, wds, (k == K_JAL) ? 2'b10 : (k == K_LW) ? 2'b01 : 2'b00);
        end else begin
            check({name, " rf_we_cycles"}, rfc, 0);
        end
        if (k inside {K_R, K_I, K_LW, K_SW, K_BEQ, K_BNE}) begin
            check({name, " ex_seen"}, ex_seen, 1);
            check({name, " alu_op"}, ex_alu, ref_alu(inst));
            check({name, " alu_src_b"}, ex_srcb, k inside {K_I, K_LW, K_SW});
            check({name, " imm_zext"}, ex_zext, inst[31:26] inside {6'h0C, 6'h0D, 6'h0E});
        end
        if (k == K_ILL) exp_illegal = 1'b1;
        if (timeout)    exp_bus_err = 1'b1;
        #1;
        check({name, " illegal"}, illegal, exp_illegal);
        check({name, " bus_err"}, bus_err, exp_bus_err);
    endtask

    initial begin
        logic [31:0] rnd, inst;
        logic [5:0] fns [10];
        logic [5:0] ops [11];
        logic [5:0] bad [5];
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h08};
        ops = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
        bad = '{6'h01, 6'h06, 6'h10, 6'h3F, 6'h21};

        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset state", state, 0);
        check("reset strobes", {pc_we, ir_we, rf_we, mem_req, mem_we}, 0);
        check("reset selects", {pc_s, rf_dst, wd_sel, alu_src_b, imm_zext}, 0);
        check("reset alu_op", alu_op, ALU_ADD);
        check("reset flags", {illegal, bus_err}, 0);
        rst = 1'b1;

        run_instr("illegal_pre", 32'hFC000000, 1'b0, 0);

        // Async reset while a load is waiting in MEM.
        inst_code = 32'h8D090004;
        mem_ack = 1'b0;
        for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
        #1;
        check("mid_mem reached", mem_req, 1);
        #2 rst = 1'b0;
        #1;
        check("mid_mem rst mem_req", mem_req, 0);
        check("mid_mem rst state", state, 0);
        check("mid_mem rst strobes", {pc_we, rf_we, ir_we, mem_we}, 0);
        check("mid_mem rst flags", {illegal, bus_err}, 0);
        exp_illegal = 1'b0;
        exp_bus_err = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("release IF0", {state, ir_we}, {3'd0, 1'b0});
        @(negedge clk);
        #1;
        check("release IF1", {state, ir_we}, {3'd1, 1'b1});
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;

        run_instr("add", 32'h012A4020, 1'b0, 0);
        run_instr("beq_taken", 32'h1109FFFD, 1'b1, 0);
        run_instr("beq_not", 32'h1109FFFD, 1'b0, 0);
        run_instr("bne_taken", 32'h1509FFFD, 1'b0, 0);
        run_instr("jal", 32'h0C000010, 1'b0, 0);
        run_instr("jr", 32'h03E00008, 1'b0, 0);
        run_instr("ori", 32'h3508FFFF, 1'b0, 0);
        run_instr("lw_wait3", 32'h8D090004, 1'b0, 3);
        run_instr("sw_ack0", 32'hAD090004, 1'b0, 0);
        run_instr("lw_edge", 32'h8D090004, 1'b0, WAIT_MAX - 1);
        run_instr("sw_timeout", 32'hAD090004, 1'b0, NO_ACK);
        run_instr("illegal_3f", 32'hFC000000, 1'b0, 0);

        for (int n = 0; n < 200; n++) begin
            rnd = $urandom;
            case ($urandom_range(0, 2))
                0: inst = {6'h00, rnd[25:6], fns[$urandom_range(0, 9)]};
                1: inst = {ops[$urandom_range(0, 10)], rnd[25:0]};
                default: begin
                    if ($urandom_range(0, 1) == 1) inst = {6'h00, rnd[25:6], bad[$urandom_range(0, 4)]};
                    else inst = {bad[$urandom_range(0, 3)], rnd[25:0]};
                end
            endcase
            run_instr("rand", inst, 1'($urandom_range(0, 1)), int'($urandom_range(0, 6)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
